serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller: it accepts WIDTH-bit operands and a borrow-in over a valid/ready handshake. It sequences a single 1-bit full-subtractor cell across the operand bits, LSB first, one bit per clock, with a registered borrow chain. It returns the difference and borrow-out over a second valid/ready handshake. It is the sequencing layer that lets one full-subtractor cell serve multi-bit subtraction in the arithmetic library.

---
 rtl/sub_pkg.sv | 30 +++
 rtl/fsub_cell.sv | 13 +
 rtl/serial_sub_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and a reference subtraction helper for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MAX_WIDTH = 32;

  // Returns {bout, diff} with diff in the low `width` bits of the 32-bit field.
  function automatic logic [MAX_WIDTH:0] ref_sub(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 bin,
    input int unsigned          width
  );
    logic [MAX_WIDTH:0]   one_hot;
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH:0]   full;
    logic                 borrow;
    one_hot = {{MAX_WIDTH{1'b0}}, 1'b1} << width;
    mask    = one_hot[MAX_WIDTH-1:0] - {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    full    = {1'b0, a & mask} - {1'b0, b & mask} - {{MAX_WIDTH{1'b0}}, bin};
    borrow  = ({1'b0, a & mask} < ({1'b0, b & mask} + {{MAX_WIDTH{1'b0}}, bin}));
    return {borrow, full[MAX_WIDTH-1:0] & mask};
  endfunction

endpackage

// File: rtl/fsub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin, bout = borrow out.
module fsub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction controller: one full-subtractor cell stepped LSB first
// across WIDTH bits, with valid/ready handshakes on operands and result.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  import sub_pkg::*;

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [WIDTH-1:0] res_next_s;
  logic             cell_d_s;
  logic             cell_bo_s;

  fsub_cell u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (brw_q),
    .d    (cell_d_s),
    .bout (cell_bo_s)
  );

  // Result register shifted right with the new difference bit entering at the MSB.
  always_comb begin
    res_next_s            = res_q >> 1'b1;
    res_next_s[WIDTH-1]   = cell_d_s;
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    res_d     = res_q;
    brw_d     = brw_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1'b1;
        b_sr_d = b_sr_q >> 1'b1;
        res_d  = res_next_s;
        brw_d  = cell_bo_s;
        cnt_d  = cnt_q + CW'(1'b1);
        if (cnt_q == LAST) begin
          // Final bit: publish the result so diff/bout stay put until the next RUN.
          diff_d  = res_next_s;
          bout_d  = cell_bo_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_serial_sub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [7:0] a, b, diff;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, bin1, bout1;
  logic [0:0] a1, b1, diff1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .diff(diff1), .bout(bout1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {bout, diff} from plain integer arithmetic on a w-bit subtraction.
  function automatic logic [8:0] model(input int w, input int av, input int bv, input int bnv);
    int m;
    int d;
    logic [8:0] r;
    m = 1 << w;
    d = ((av - bv - bnv) % m + m) % m;
    r[7:0] = d[7:0];
    r[8]   = (av < bv + bnv);
    return r;
  endfunction

  // Issue one WIDTH=8 operation and wait for its result; leaves the DUT in DONE.
  task automatic do_txn8(input logic [7:0] av, input logic [7:0] bv, input logic bnv, input string tag);
    logic [8:0] e;
    int n;
    e = model(8, av, bv, bnv);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    a = av; b = bv; bin = bnv; in_valid = 1'b1;
    tick;
    acc_cyc = cyc;
    in_valid = 1'b0;
    chk({tag, "_run_busy"}, {in_ready, out_valid}, 2'b00);
    n = 0;
    while (!out_valid && n < 40) begin
      tick;
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_diff"}, diff, e[7:0]);
    chk({tag, "_bout"}, bout, e[8]);
  endtask

  initial begin
    logic [8:0] e;
    int n;
    int prev;
    logic [7:0] ra, rb;
    logic rbin;
    logic [2:0] v;

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0; out_ready1 = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_bout", bout, 1'b0);
    chk("rst_in_ready1", in_ready1, 1'b1);

    do_txn8(8'h5A, 8'h23, 1'b0, "basic");
    chk("basic_const_diff", diff, 8'h37);
    tick;
    do_txn8(8'h00, 8'h01, 1'b0, "underflow");
    chk("underflow_const", {bout, diff}, 9'h1FF);
    tick;
    do_txn8(8'hFF, 8'hFF, 1'b1, "ffbin");
    chk("ffbin_const", {bout, diff}, 9'h1FF);
    tick;

    // Reset in the third RUN cycle discards the operation.
    a = 8'h5A; b = 8'h23; bin = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_diff", diff, 8'h00);
    chk("midrst_bout", bout, 1'b0);
    do_txn8(8'h10, 8'h01, 1'b0, "postrst");
    chk("postrst_const", {bout, diff}, 9'h00F);
    tick;

    // Backpressure: stall five cycles, offering new operands that must be ignored.
    out_ready = 1'b0;
    do_txn8(8'hC3, 8'h3C, 1'b0, "bp");
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        in_valid = 1'b1; a = 8'h11; b = 8'h22; bin = 1'b1;
      end
      tick;
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold", {bout, diff}, 9'h087);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_release_out_valid", out_valid, 1'b0);
    chk("bp_release_in_ready", in_ready, 1'b1);
    do_txn8(8'h80, 8'h01, 1'b1, "after_bp");
    tick;

    // WIDTH=1 exhaustive sweep over {a, b, bin}.
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      e = model(1, v[2], v[1], v[0]);
      chk("w1_in_ready", in_ready1, 1'b1);
      a1 = v[2]; b1 = v[1]; bin1 = v[0]; in_valid1 = 1'b1;
      tick;
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 10) begin
        tick;
        n++;
      end
      chk("w1_latency", n, 1);
      chk("w1_diff", diff1, e[0]);
      chk("w1_bout", bout1, e[8]);
      tick;
    end

    // Back-to-back random traffic with out_ready held high.
    prev = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rbin = 1'($urandom);
      do_txn8(ra, rb, rbin, "rand");
      if (i > 0) begin
        chk("rand_spacing", acc_cyc - prev, 10);
      end
      prev = acc_cyc;
      tick;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
